// File: rtl/adc_reader.sv
// Dual-channel serial ADC reader: drives shared CS/SCLK, shifts in two 16-bit
// frames (4 leading zeros + 12-bit sample, MSB first) and strobes both results.
module adc_reader #(
    parameter int HALF_DIV    = 1,
    parameter int QUIET_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        pmod_cs,
    output logic        pmod_sclk,
    input  logic        pmod_d0,
    input  logic        pmod_d1,
    output logic [11:0] data_a,
    output logic [11:0] data_b,
    output logic        valid,
    output logic        zero_err,
    output logic        busy
);

    localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int CW = ($clog2(QUIET_TICKS) > 6) ? $clog2(QUIET_TICKS) : 6;

    localparam logic [DW-1:0] DIV_LAST   = DW'(HALF_DIV - 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(31);
    localparam logic [CW-1:0] CONV_END   = CW'(32);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } state_t;

    function automatic logic lead_bits_set(input logic [15:0] a, input logic [15:0] b);
        return |{a[15:12], b[15:12]};
    endfunction

    state_t        state_r, state_s;
    logic [DW-1:0] div_r, div_s;
    logic [CW-1:0] half_r, half_s;
    logic [15:0]   sr_a_r, sr_a_s, sr_b_r, sr_b_s;
    logic          done_r, done_s;
    logic          cs_r, cs_s, sclk_r, sclk_s;
    logic [11:0]   data_a_r, data_a_s, data_b_r, data_b_s;
    logic          valid_r, valid_s, zero_err_r, zero_err_s, busy_r, busy_s;
    logic          tick_s;

    // Next-state and next-output logic; half_r counts elapsed ticks in CONV/QUIET.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        half_s     = half_r;
        sr_a_s     = sr_a_r;
        sr_b_s     = sr_b_r;
        cs_s       = cs_r;
        sclk_s     = sclk_r;
        done_s     = 1'b0;
        tick_s     = (div_r == DIV_LAST);
        valid_s    = done_r;
        data_a_s   = done_r ? sr_a_r[11:0] : data_a_r;
        data_b_s   = done_r ? sr_b_r[11:0] : data_b_r;
        zero_err_s = done_r ? lead_bits_set(sr_a_r, sr_b_r) : zero_err_r;
        case (state_r)
            IDLE: begin
                cs_s   = 1'b1;
                sclk_s = 1'b1;
                div_s  = '0;
                half_s = '0;
                if (en) begin
                    state_s = CONV;
                    cs_s    = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (tick_s) begin
                    div_s  = '0;
                    half_s = half_r + CW'(1);
                    if (half_r == CONV_END) begin
                        state_s = QUIET;
                        cs_s    = 1'b1;
                        half_s  = '0;
                    end else if (!half_r[0]) begin
                        sclk_s = 1'b0;
                    end else begin
                        // Rising SCLK edge: capture the bit the ADC drove on the falling edge.
                        sclk_s = 1'b1;
                        sr_a_s = {sr_a_r[14:0], pmod_d0};
                        sr_b_s = {sr_b_r[14:0], pmod_d1};
                        done_s = (half_r == LAST_BIT);
                    end
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            QUIET: begin
                if (tick_s) begin
                    div_s = '0;
                    if (half_r == QUIET_LAST) begin
                        half_s = '0;
                        if (en) begin
                            state_s = CONV;
                            cs_s    = 1'b0;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        half_s = half_r + CW'(1);
                    end
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cs_s    = 1'b1;
                sclk_s  = 1'b1;
                div_s   = '0;
                half_s  = '0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            div_r      <= '0;
            half_r     <= '0;
            sr_a_r     <= 16'h0000;
            sr_b_r     <= 16'h0000;
            done_r     <= 1'b0;
            cs_r       <= 1'b1;
            sclk_r     <= 1'b1;
            data_a_r   <= 12'h000;
            data_b_r   <= 12'h000;
            valid_r    <= 1'b0;
            zero_err_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            half_r     <= half_s;
            sr_a_r     <= sr_a_s;
            sr_b_r     <= sr_b_s;
            done_r     <= done_s;
            cs_r       <= cs_s;
            sclk_r     <= sclk_s;
            data_a_r   <= data_a_s;
            data_b_r   <= data_b_s;
            valid_r    <= valid_s;
            zero_err_r <= zero_err_s;
            busy_r     <= busy_s;
        end
    end

    assign pmod_cs   = cs_r;
    assign pmod_sclk = sclk_r;
    assign data_a    = data_a_r;
    assign data_b    = data_b_r;
    assign valid     = valid_r;
    assign zero_err  = zero_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_adc_reader.sv
// Bench for adc_reader: ADC pin model, timing-rule model checked every cycle,
// and directed checks with hand-computed cycle offsets and data.
module tb_adc_reader;

    localparam int H = 1;
    localparam int Q = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b0, d0 = 1'b0, d1 = 1'b0;
    logic        cs, sclk, valid, zero_err, busy;
    logic [11:0] data_a, data_b;

    logic        en3 = 1'b0, d0_3 = 1'b1, d1_3 = 1'b0;
    logic        cs3, sclk3, valid3, ze3, busy3;
    logic [11:0] da3, db3;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    adc_reader #(.HALF_DIV(1), .QUIET_TICKS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .pmod_cs(cs), .pmod_sclk(sclk),
        .pmod_d0(d0), .pmod_d1(d1), .data_a(data_a), .data_b(data_b),
        .valid(valid), .zero_err(zero_err), .busy(busy)
    );

    adc_reader #(.HALF_DIV(3), .QUIET_TICKS(1)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .pmod_cs(cs3), .pmod_sclk(sclk3),
        .pmod_d0(d0_3), .pmod_d1(d1_3), .data_a(da3), .data_b(db3),
        .valid(valid3), .zero_err(ze3), .busy(busy3)
    );

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%h required=%h", name, edge_cnt, act, exp);
        end
    endtask

    // ADC pin model: loads a word on CS fall, shifts MSB first on each SCLK fall.
    logic [15:0] next_a = 16'h0000, next_b = 16'h0000, ld_a = 16'h0000, ld_b = 16'h0000;
    bit          inc = 1'b0;
    int          idx = 0;

    initial forever begin
        @(negedge cs);
        ld_a = next_a;
        ld_b = next_b;
        idx  = 0;
        if (inc) begin
            next_a = next_a + 16'd1;
            next_b = next_b + 16'd1;
        end
    end

    initial forever begin
        @(negedge sclk);
        if (cs === 1'b0 && idx < 16) begin
            d0 = ld_a[15 - idx];
            d1 = ld_b[15 - idx];
            idx++;
        end
    end

    // Timing model: outputs as functions of the cycle offset from frame start.
    bit          m_on = 1'b0, m_act = 1'b0;
    int          m_t0 = 0, rel = 0;
    logic [11:0] ea = 12'h000, eb = 12'h000;
    logic        ez = 1'b0, e_cs, e_sclk, e_val;

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            rel    = edge_cnt - m_t0;
            e_cs   = 1'b1;
            e_sclk = 1'b1;
            e_val  = 1'b0;
            if (m_act) begin
                e_cs   = (rel >= 33 * H);
                e_sclk = !(rel >= H && rel < 32 * H && ((rel / H) % 2 == 1));
                e_val  = (rel == 32 * H + 1);
            end
            if (e_val) begin
                ea = ld_a[11:0];
                eb = ld_b[11:0];
                ez = (ld_a[15:12] != 4'h0) || (ld_b[15:12] != 4'h0);
            end
            chk("m_cs", cs, e_cs);
            chk("m_sclk", sclk, e_sclk);
            chk("m_valid", valid, e_val);
            chk("m_busy", busy, m_act);
            chk("m_data_a", data_a, ea);
            chk("m_data_b", data_b, eb);
            chk("m_zero_err", zero_err, ez);
        end
        if (rst) begin
            m_on  = 1'b1;
            m_act = 1'b0;
            ea    = 12'h000;
            eb    = 12'h000;
            ez    = 1'b0;
        end else if (m_on) begin
            if (!m_act) begin
                if (en) begin
                    m_act = 1'b1;
                    m_t0  = edge_cnt + 1;
                end
            end else if (edge_cnt - m_t0 == (33 + Q) * H - 1) begin
                if (en) m_t0 = m_t0 + (33 + Q) * H;
                else    m_act = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (edge_cnt < n) step();
    endtask

    task automatic wait_cs_low(output int t0);
        t0 = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (cs === 1'b0) begin
                t0 = edge_cnt;
                break;
            end
        end
        if (t0 < 0) begin
            checks++;
            errors++;
            $display("FAIL cs_low_timeout: actual=no cs fall required=cs fall within 60 clk");
            t0 = edge_cnt;
        end
    endtask

    task automatic start_pulse(output int t0);
        en = 1'b1;
        wait_cs_low(t0);
        en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t3, vt[4];
        bit found, saw;

        repeat (3) step();
        chk("rst_cs", cs, 1'b1);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_data_a", data_a, 12'h000);
        chk("rst_valid", valid, 1'b0);
        chk("rst_zero_err", zero_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst3_cs", cs3, 1'b1);
        chk("rst3_busy", busy3, 1'b0);
        rst = 1'b0;
        step();

        // HALF_DIV=3, QUIET_TICKS=1, en held
        en3 = 1'b1;
        t3 = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cs3 === 1'b0) begin
                t3 = edge_cnt;
                break;
            end
        end
        chk("h3_cs_fall_seen", (t3 >= 0), 1'b1);
        wait_until(t3 + 2);  chk("h3_sclk_t2", sclk3, 1'b1);
        wait_until(t3 + 3);  chk("h3_sclk_t3", sclk3, 1'b0);
        wait_until(t3 + 5);  chk("h3_sclk_t5", sclk3, 1'b0);
        wait_until(t3 + 6);  chk("h3_sclk_t6", sclk3, 1'b1);
        wait_until(t3 + 96); chk("h3_valid_t96", valid3, 1'b0);
        wait_until(t3 + 97);
        chk("h3_valid_t97", valid3, 1'b1);
        chk("h3_data_a", da3, 12'hFFF);
        chk("h3_data_b", db3, 12'h000);
        chk("h3_zero_err", ze3, 1'b1);
        wait_until(t3 + 98);  chk("h3_cs_t98", cs3, 1'b0);
        wait_until(t3 + 99);  chk("h3_cs_t99", cs3, 1'b1);
        wait_until(t3 + 101); chk("h3_cs_t101", cs3, 1'b1);
        wait_until(t3 + 102); chk("h3_cs_t102", cs3, 1'b0);
        en3 = 1'b0;

        // Single frame, defaults
        next_a = 16'h0ABC;
        next_b = 16'h0123;
        start_pulse(t0);
        wait_until(t0 + 32);
        chk("sf_cs_t32", cs, 1'b0);
        chk("sf_valid_t32", valid, 1'b0);
        wait_until(t0 + 33);
        chk("sf_valid_t33", valid, 1'b1);
        chk("sf_data_a", data_a, 12'hABC);
        chk("sf_data_b", data_b, 12'h123);
        chk("sf_zero_err", zero_err, 1'b0);
        chk("sf_cs_t33", cs, 1'b1);
        wait_until(t0 + 34);
        chk("sf_valid_t34", valid, 1'b0);
        chk("sf_busy_t34", busy, 1'b1);
        wait_until(t0 + 36);
        chk("sf_busy_t36", busy, 1'b0);
        chk("sf_data_hold", data_a, 12'hABC);
        wait_until(t0 + 40);

        // Leading-bit error, then a clean frame clears it
        next_a = 16'h8FFF;
        next_b = 16'h0000;
        start_pulse(t0);
        wait_until(t0 + 33);
        chk("lb_valid", valid, 1'b1);
        chk("lb_data_a", data_a, 12'hFFF);
        chk("lb_data_b", data_b, 12'h000);
        chk("lb_zero_err", zero_err, 1'b1);
        wait_until(t0 + 38);
        chk("lb_zero_err_hold", zero_err, 1'b1);
        wait_until(t0 + 40);
        next_a = 16'h0555;
        next_b = 16'h0AAA;
        start_pulse(t0);
        wait_until(t0 + 33);
        chk("cl_data_a", data_a, 12'h555);
        chk("cl_data_b", data_b, 12'hAAA);
        chk("cl_zero_err", zero_err, 1'b0);
        wait_until(t0 + 40);

        // Continuous mode: four back-to-back frames
        next_a = 16'h0001;
        next_b = 16'h0001;
        inc    = 1'b1;
        en     = 1'b1;
        for (int f = 0; f < 4; f++) begin
            found = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (valid === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("cm_valid_seen", found, 1'b1);
            vt[f] = edge_cnt;
            chk("cm_data_a", data_a, 12'(f + 1));
            chk("cm_data_b", data_b, 12'(f + 1));
            if (f > 0) chk("cm_period", vt[f] - vt[f-1], 32'd35);
        end
        en  = 1'b0;
        inc = 1'b0;
        wait_until(vt[3] + 10);
        chk("cm_idle_after", busy, 1'b0);

        // Reset mid-frame
        next_a = 16'h0777;
        next_b = 16'h0777;
        start_pulse(t0);
        wait_until(t0 + 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_cs", cs, 1'b1);
        chk("rm_sclk", sclk, 1'b1);
        chk("rm_data_a", data_a, 12'h000);
        chk("rm_data_b", data_b, 12'h000);
        chk("rm_busy", busy, 1'b0);
        saw = 1'b0;
        repeat (40) begin
            step();
            if (valid === 1'b1) saw = 1'b1;
        end
        chk("rm_no_valid", saw, 1'b0);

        // en drop mid-frame
        next_a = 16'h0246;
        next_b = 16'h0135;
        en = 1'b1;
        wait_cs_low(t0);
        wait_until(t0 + 4);
        en = 1'b0;
        wait_until(t0 + 33);
        chk("ed_valid", valid, 1'b1);
        chk("ed_data_a", data_a, 12'h246);
        chk("ed_data_b", data_b, 12'h135);
        saw = 1'b0;
        repeat (60) begin
            step();
            if (cs === 1'b0) saw = 1'b1;
        end
        chk("ed_no_second_frame", saw, 1'b0);
        chk("ed_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
